// File: rtl/pong_score.sv
// pong_score: Pong scoreboard stage.
//
// Counts points from the wall-collision levels (one point per rising edge),
// keeps a two-digit BCD score per player, flags the end of the match when a
// score reaches WIN_SCORE, and renders both scores as seven-segment digits
// into a registered pixel-draw bit.
//
// Ports:
//   clk_pix    in   pixel clock, the only clock
//   rst        in   synchronous active-high reset
//   clear      in   start a new match (zero scores, drop game_over)
//   pt_p1      in   level, rises when player 1 scores
//   pt_p2      in   level, rises when player 2 scores
//   sx, sy     in   current screen coordinate (CORDW bits each)
//   score_p1   out  player-1 score, BCD {tens, units}
//   score_p2   out  player-2 score, BCD {tens, units}
//   game_over  out  high once either score has reached WIN_SCORE
//   winner     out  0 = player 1, 1 = player 2; meaningful while game_over
//   score_draw out  current pixel (one cycle ago) lies on a lit segment
module pong_score #(
    parameter int CORDW     = 10,
    parameter int WIN_SCORE = 11,
    parameter int DIG_W     = 20,
    parameter int DIG_H     = 36,
    parameter int SEG_T     = 4,
    parameter int DIG_GAP   = 8,
    parameter int P1_X      = 232,
    parameter int P2_X      = 360,
    parameter int DIG_Y     = 16
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic             clear,
    input  logic             pt_p1,
    input  logic             pt_p2,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    output logic [7:0]       score_p1,
    output logic [7:0]       score_p2,
    output logic             game_over,
    output logic             winner,
    output logic             score_draw
);

    // One extra bit so box-edge sums and differences never wrap into range.
    localparam int CW = CORDW + 1;

    localparam logic [6:0]    WIN_L   = 7'(WIN_SCORE);
    localparam logic [CW-1:0] Y0_L    = CW'(DIG_Y);
    localparam logic [CW-1:0] W_L     = CW'(DIG_W);
    localparam logic [CW-1:0] H_L     = CW'(DIG_H);
    localparam logic [CW-1:0] T_L     = CW'(SEG_T);
    localparam logic [CW-1:0] W_MIN_T = CW'(DIG_W - SEG_T);
    localparam logic [CW-1:0] H_MIN_T = CW'(DIG_H - SEG_T);
    localparam logic [CW-1:0] MID_LO  = CW'(DIG_H / 2 - SEG_T / 2);
    localparam logic [CW-1:0] MID_HI  = CW'(DIG_H / 2 + SEG_T / 2);

    // ------------------------------------------------------------------
    // Score keeping
    // ------------------------------------------------------------------
    logic       prev_p1_reg, prev_p2_reg;
    logic [7:0] score_p1_reg, score_p2_reg;
    logic [7:0] score_p1_next, score_p2_next;
    logic       game_over_reg, winner_reg;
    logic       edge_p1, edge_p2;
    logic       p1_at_win, p2_at_win;
    logic       point_ok;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [6:0] bcd_val(input logic [7:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

    assign edge_p1   = pt_p1 & ~prev_p1_reg;
    assign edge_p2   = pt_p2 & ~prev_p2_reg;
    assign p1_at_win = (bcd_val(score_p1_reg) == WIN_L);
    assign p2_at_win = (bcd_val(score_p2_reg) == WIN_L);

    // game_over is registered one cycle after the winning increment; points
    // are already refused in that gap so a score can never pass WIN_SCORE.
    assign point_ok = ~game_over_reg & ~p1_at_win & ~p2_at_win;

    always_comb begin
        score_p1_next = score_p1_reg;
        score_p2_next = score_p2_reg;
        if (point_ok) begin
            // Simultaneous edges are a draw: neither side scores.
            if (edge_p1 && !edge_p2) begin
                score_p1_next = bcd_inc(score_p1_reg);
            end else if (edge_p2 && !edge_p1) begin
                score_p2_next = bcd_inc(score_p2_reg);
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            // History resets high: a level already up at reset never scores.
            prev_p1_reg   <= 1'b1;
            prev_p2_reg   <= 1'b1;
            score_p1_reg  <= 8'h00;
            score_p2_reg  <= 8'h00;
            game_over_reg <= 1'b0;
            winner_reg    <= 1'b0;
        end else if (clear) begin
            // Track the current levels so clearing never leaves a false edge.
            prev_p1_reg   <= pt_p1;
            prev_p2_reg   <= pt_p2;
            score_p1_reg  <= 8'h00;
            score_p2_reg  <= 8'h00;
            game_over_reg <= 1'b0;
            winner_reg    <= 1'b0;
        end else begin
            prev_p1_reg  <= pt_p1;
            prev_p2_reg  <= pt_p2;
            score_p1_reg <= score_p1_next;
            score_p2_reg <= score_p2_next;
            if (!game_over_reg && (p1_at_win || p2_at_win)) begin
                game_over_reg <= 1'b1;
                winner_reg    <= p2_at_win;
            end
        end
    end

    // ------------------------------------------------------------------
    // Seven-segment rendering
    // ------------------------------------------------------------------
    // Segment bit order {a,b,c,d,e,f,g} = bits [6:0].
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic [CW-1:0] sx_ext, sy_ext;
    logic [3:0]    digit_val [4];
    logic [3:0]    digit_blank;
    logic [3:0]    digit_hit;
    logic          score_draw_reg;

    assign sx_ext = {1'b0, sx};
    assign sy_ext = {1'b0, sy};

    // Digit order: p1 tens, p1 units, p2 tens, p2 units.
    assign digit_val[0] = score_p1_reg[7:4];
    assign digit_val[1] = score_p1_reg[3:0];
    assign digit_val[2] = score_p2_reg[7:4];
    assign digit_val[3] = score_p2_reg[3:0];

    // Leading-zero suppression on the tens digits only.
    assign digit_blank[0] = (score_p1_reg[7:4] == 4'd0);
    assign digit_blank[1] = 1'b0;
    assign digit_blank[2] = (score_p2_reg[7:4] == 4'd0);
    assign digit_blank[3] = 1'b0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam int BOX_X = ((gi < 2) ? P1_X : P2_X)
                                 + (((gi % 2) == 1) ? (DIG_W + DIG_GAP) : 0);
            localparam logic [CW-1:0] X0_L = CW'(BOX_X);

            logic [CW-1:0] rel_x, rel_y;
            logic          in_box;
            logic [6:0]    seg_area;
            logic [6:0]    seg_lit;

            assign rel_x  = sx_ext - X0_L;
            assign rel_y  = sy_ext - Y0_L;
            assign in_box = (sx_ext >= X0_L) && (rel_x < W_L)
                         && (sy_ext >= Y0_L) && (rel_y < H_L);

            // Horizontal segments span the full box width, so in_box already
            // bounds their x range.
            assign seg_area[6] = (rel_y < T_L);                         // a
            assign seg_area[5] = (rel_x >= W_MIN_T) && (rel_y < MID_HI); // b
            assign seg_area[4] = (rel_x >= W_MIN_T) && (rel_y >= MID_LO);// c
            assign seg_area[3] = (rel_y >= H_MIN_T);                    // d
            assign seg_area[2] = (rel_x < T_L) && (rel_y >= MID_LO);    // e
            assign seg_area[1] = (rel_x < T_L) && (rel_y < MID_HI);     // f
            assign seg_area[0] = (rel_y >= MID_LO) && (rel_y < MID_HI); // g

            assign seg_lit = digit_blank[gi] ? 7'b0000000 : seg_decode(digit_val[gi]);

            assign digit_hit[gi] = in_box && ((seg_area & seg_lit) != 7'b0000000);
        end
    endgenerate

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            score_draw_reg <= 1'b0;
        end else begin
            score_draw_reg <= |digit_hit;
        end
    end

    assign score_p1   = score_p1_reg;
    assign score_p2   = score_p2_reg;
    assign game_over  = game_over_reg;
    assign winner     = winner_reg;
    assign score_draw = score_draw_reg;

endmodule

// File: tb/tb_pong_score.sv
// Self-checking bench for pong_score: directed scenarios plus randomized
// point/clear/coordinate stimulus, compared every cycle against an integer
// scoreboard model with a rectangle-based digit renderer.
module tb_pong_score;
    localparam int CORDW   = 10;
    localparam int WIN     = 11;
    localparam int DIG_W   = 20;
    localparam int DIG_H   = 36;
    localparam int SEG_T   = 4;
    localparam int DIG_GAP = 8;
    localparam int P1_X    = 232;
    localparam int P2_X    = 360;
    localparam int DIG_Y   = 16;

    logic             clk_pix = 1'b0;
    logic             rst     = 1'b1;
    logic             clear   = 1'b0;
    logic             pt_p1   = 1'b0;
    logic             pt_p2   = 1'b0;
    logic [CORDW-1:0] sx      = '0;
    logic [CORDW-1:0] sy      = '0;
    logic [7:0]       score_p1, score_p2;
    logic             game_over, winner, score_draw;

    always #5 clk_pix = ~clk_pix;

    pong_score #(
        .CORDW(CORDW), .WIN_SCORE(WIN), .DIG_W(DIG_W), .DIG_H(DIG_H),
        .SEG_T(SEG_T), .DIG_GAP(DIG_GAP), .P1_X(P1_X), .P2_X(P2_X), .DIG_Y(DIG_Y)
    ) dut (
        .clk_pix(clk_pix), .rst(rst), .clear(clear), .pt_p1(pt_p1), .pt_p2(pt_p2),
        .sx(sx), .sy(sy), .score_p1(score_p1), .score_p2(score_p2),
        .game_over(game_over), .winner(winner), .score_draw(score_draw)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_s1 = 0, m_s2 = 0;
    bit m_over = 0, m_win = 0, m_prev1 = 1, m_prev2 = 1, m_draw = 0;

    string seg_tab [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic bit in_seg(byte s, int rx, int ry);
        int lo = DIG_H / 2 - SEG_T / 2;
        int hi = DIG_H / 2 + SEG_T / 2;
        case (s)
            "a": return ry < SEG_T;
            "b": return rx >= DIG_W - SEG_T && ry < hi;
            "c": return rx >= DIG_W - SEG_T && ry >= lo;
            "d": return ry >= DIG_H - SEG_T;
            "e": return rx < SEG_T && ry >= lo;
            "f": return rx < SEG_T && ry < hi;
            "g": return ry >= lo && ry < hi;
            default: return 0;
        endcase
    endfunction

    function automatic bit digit_lit(int d, int ox, int x, int y);
        int rx = x - ox;
        int ry = y - DIG_Y;
        string s = seg_tab[d];
        if (rx < 0 || rx >= DIG_W || ry < 0 || ry >= DIG_H) return 0;
        for (int k = 0; k < s.len(); k++)
            if (in_seg(s[k], rx, ry)) return 1;
        return 0;
    endfunction

    function automatic bit pixel_lit(int x, int y, int a, int b);
        for (int p = 0; p < 2; p++) begin
            int v    = (p == 0) ? a : b;
            int base = (p == 0) ? P1_X : P2_X;
            if (v / 10 != 0 && digit_lit(v / 10, base, x, y)) return 1;
            if (digit_lit(v % 10, base + DIG_W + DIG_GAP, x, y)) return 1;
        end
        return 0;
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    // One clock: model updates on the edge, DUT compared on the falling edge.
    task automatic tick();
        bit e1, e2;
        @(posedge clk_pix);
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 0;
            m_prev1 = 1; m_prev2 = 1; m_draw = 0;
        end else begin
            m_draw = pixel_lit(int'(sx), int'(sy), m_s1, m_s2);
            if (clear) begin
                m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 0;
            end else begin
                e1 = pt_p1 && !m_prev1;
                e2 = pt_p2 && !m_prev2;
                if (!m_over && (m_s1 == WIN || m_s2 == WIN)) begin
                    m_over = 1;
                    m_win  = (m_s2 == WIN);
                end else if (!m_over) begin
                    if (e1 && !e2) m_s1++;
                    else if (e2 && !e1) m_s2++;
                end
            end
            m_prev1 = pt_p1;
            m_prev2 = pt_p2;
        end
        @(negedge clk_pix);
        check("score_p1", score_p1, to_bcd(m_s1));
        check("score_p2", score_p2, to_bcd(m_s2));
        check("game_over", game_over, m_over);
        check("winner", winner, m_win);
        check("score_draw", score_draw, m_draw);
    endtask

    task automatic pulse_p1();
        pt_p1 = 1; tick(); pt_p1 = 0; tick();
    endtask

    task automatic pulse_p2();
        pt_p2 = 1; tick(); pt_p2 = 0; tick();
    endtask

    task automatic do_clear();
        clear = 1; tick(); clear = 0;
    endtask

    int cnt_all, cnt_tens, zero_lit;

    initial begin
        // Level held high across reset release never scores.
        rst = 1; pt_p1 = 1;
        repeat (3) tick();
        check("rst_score_p1", score_p1, 8'h00);
        check("rst_draw", score_draw, 0);
        rst = 0;
        repeat (3) tick();
        check("hold_thru_rst", score_p1, 8'h00);
        pt_p1 = 0; tick();
        pt_p1 = 1; tick();
        check("first_edge", score_p1, 8'h01);
        repeat (1000) tick();
        check("held_level", score_p1, 8'h01);
        pt_p1 = 0; tick();

        // Ten player-2 points carry into the tens digit.
        do_clear();
        repeat (10) pulse_p2();
        check("p2_carry", score_p2, 8'h10);
        sx = CORDW'(P2_X + 2);  sy = CORDW'(DIG_Y + 18); tick();
        check("tens1_left_dark", score_draw, 0);
        sx = CORDW'(P2_X + 17); sy = CORDW'(DIG_Y + 5);  tick();
        check("tens1_b_lit", score_draw, 1);
        sx = CORDW'(P2_X + DIG_W + DIG_GAP + 1);  sy = CORDW'(DIG_Y + 20); tick();
        check("units0_e_lit", score_draw, 1);
        sx = CORDW'(P2_X + DIG_W + DIG_GAP + 10); sy = CORDW'(DIG_Y + 18); tick();
        check("units0_centre_dark", score_draw, 0);

        // Simultaneous edges are a draw.
        do_clear();
        repeat (3) pulse_p1();
        repeat (5) pulse_p2();
        pt_p1 = 1; pt_p2 = 1; tick();
        check("draw_p1", score_p1, 8'h03);
        check("draw_p2", score_p2, 8'h05);
        pt_p1 = 0; pt_p2 = 0; tick();

        // Match to WIN points; game_over lags the score by one cycle.
        do_clear();
        repeat (WIN - 1) pulse_p1();
        pt_p1 = 1; tick();
        check("win_score", score_p1, 8'h11);
        check("win_not_yet", game_over, 0);
        pt_p1 = 0; tick();
        check("win_over", game_over, 1);
        check("win_who", winner, 0);
        pulse_p2();
        check("over_ignores_p2", score_p2, 8'h00);

        // clear beats a coincident point edge.
        clear = 1; pt_p1 = 1; tick(); clear = 0;
        check("clr_p1", score_p1, 8'h00);
        check("clr_over", game_over, 0);
        tick();
        check("clr_no_point", score_p1, 8'h00);
        pt_p1 = 0; tick();
        pt_p1 = 1; tick();
        check("after_clr_edge", score_p1, 8'h01);
        pt_p1 = 0;

        // Frame-region scan at 0:0.
        do_clear();
        cnt_all = 0; cnt_tens = 0; zero_lit = 0;
        for (int y = 0; y < DIG_Y + DIG_H + 8; y++) begin
            for (int x = P1_X - 8; x < P2_X + 2 * DIG_W + DIG_GAP + 8; x++) begin
                sx = CORDW'(x); sy = CORDW'(y);
                tick();
                if (score_draw === 1'b1) begin
                    cnt_all++;
                    if ((x >= P1_X && x < P1_X + DIG_W) || (x >= P2_X && x < P2_X + DIG_W))
                        cnt_tens++;
                end
            end
        end
        for (int y = 0; y < DIG_H; y++)
            for (int x = 0; x < DIG_W; x++)
                if (digit_lit(0, 0, x, y + DIG_Y)) zero_lit++;
        check("scan_lit_count", cnt_all, 2 * zero_lit);
        check("scan_tens_dark", cnt_tens, 0);

        // Randomized play.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) pt_p1 = ~pt_p1;
            if ($urandom_range(0, 3) == 0) pt_p2 = ~pt_p2;
            clear = ($urandom_range(0, 299) == 0);
            rst   = ($urandom_range(0, 1999) == 0);
            sx = CORDW'($urandom_range(P1_X - 10, P2_X + 60));
            sy = CORDW'($urandom_range(DIG_Y - 6, DIG_Y + DIG_H + 6));
            tick();
        end
        rst = 0; clear = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
